ttl_cen_gen_sync: RTL and testbench
===================================

Name: ttl_cen_gen_sync

Overview:
Master-clock enable generator that drives the Cen inputs of the synchronous TTL flip-flop and counter models.
- Emulates the original PCB's crystal-derived clock as a level, Cen_lvl, plus single-cycle edge strobes, all in the Clk domain.
- A fractional-N accumulator sets the emulated clock rate.
- A ripple chain of J=K=1 divide-by-2 stages emulates the board's divided clocks.
- A Run/Stopped handshake freezes emulated time cleanly for pause and debug.

Parameters:
NUM, 1, numerator of emulated frequency ratio (f_emu = f_Clk*NUM/DEN); 1 <= NUM, 2*NUM <= DEN.
DEN, 4, denominator of ratio.
ACC_W, 16, accumulator width; must satisfy 2^ACC_W > DEN + 2*NUM.
DIV_STAGES, 3, number of cascaded /2 stages (1..8).

Ports:
Clk  in  1  system clock
Reset_n  in  1  synchronous reset, active-low
Run  in  1  1 = advance emulated clock; 0 = request halt
Cen_lvl  out  1  emulated clock level
Cen_rise  out  1  1-cycle strobe, Cen_lvl went 0->1 this edge
Cen_fall  out  1  1-cycle strobe, Cen_lvl went 1->0 this edge
Div_lvl  out  DIV_STAGES  emulated /2,/4,... clock levels
Div_fall  out  DIV_STAGES  1-cycle strobe per stage, level went 1->0
Stopped  out  1  1 = halted, emulated time frozen

Behaviour:
- Reset is synchronous and active-low on clock Clk. It overrides everything, including mid-operation.
  - Post-reset values: acc=0, Cen_lvl=1, Cen_rise=0, Cen_fall=0, Div_lvl=0, Div_fall=0, Stopped=0, state=RUN.
  - Cen_lvl resets to 1 so downstream falling-edge detectors, whose last_cen resets to 1, see no spurious edge.
- Accumulator, evaluated every Clk while state is RUN or DRAIN:
  - sum = acc + 2*NUM, computed at ACC_W bits with no overflow by parameter rule.
  - If sum >= DEN: acc <= sum - DEN, and toggle=1.
  - Otherwise: acc <= sum, and toggle=0.
- Toggle event:
  - Cen_lvl <= ~Cen_lvl.
  - Cen_rise <= toggle & ~Cen_lvl.
  - Cen_fall <= toggle & Cen_lvl.
  - Strobes are registered, coincide with the level change, and are 0 in every other cycle.
- Divider chain, updated on the same edge with no extra latency:
  - fall_in[0] = toggle & Cen_lvl; fall_in[k] = fall_in[k-1] & Div_lvl[k-1].
  - Div_lvl[k] toggles when fall_in[k] is 1.
  - Div_fall[k] <= fall_in[k] & Div_lvl[k].
- State machine RUN / DRAIN / HALT:
  - RUN, Run=0: go to HALT if Cen_lvl==1 and toggle==0. If this cycle's toggle is a rise, also go to HALT; that rise still completes. Otherwise go to DRAIN.
  - DRAIN: keep advancing. Go to HALT on the cycle whose toggle is a rise, or earlier if Run returns to 1, in which case go back to RUN.
  - HALT: acc, Cen_lvl, and Div_lvl are frozen; all strobes are 0; Stopped=1 (registered, asserts on the HALT entry edge).
  - HALT, Run=1: go to RUN and Stopped <= 0. Accumulation resumes on the following edge from the held acc, so no phase is lost.
- Halt always leaves Cen_lvl=1, so the whole machine freezes at a consistent high phase.
- A ratio of 2*NUM == DEN is legal and gives a toggle on every cycle, i.e. f_Clk/2.
- Illegal parameters (NUM=0, 2*NUM > DEN, ACC_W too small) are rejected at elaboration by a generate-time error.

Decomposition:
- Shared package ttl_timing_pkg holds:
  - localparam state encodings RUN=2'd0, DRAIN=2'd1, HALT=2'd2;
  - function clog2 for ACC_W checks;
  - the parameter-legality check function.
- One sub-module, ttl_cen_div_stage: a single J=K=1 toggle stage.
  - Inputs: Clk, Reset_n, Hold, Fall_in.
  - Outputs: Lvl, Fall_out (combinational Fall_in & Lvl), Fall_q (registered Div_fall).
  - Instantiated DIV_STAGES times in a generate loop.

Test Plan:
- NUM=1, DEN=4, Run=1 after reset -> Cen_lvl toggles every 2 Clk. First Cen_fall comes on the 2nd edge after reset release, then Cen_rise 2 edges later; period is 4 Clk.
- NUM=3, DEN=8 over 16 Clk -> exactly 12 toggles (6 rise, 6 fall). acc sequence is 6,4,2,0,6,4,2,0,...; toggles occur on cycles 2,3,4,6,7,8,...
- DIV_STAGES=3, NUM=1, DEN=2 -> Div_lvl[0] period 4 Clk, Div_lvl[1] period 8, Div_lvl[2] period 16. Div_fall[2] pulses once per 16 Clk, on the same edge as Cen_fall, Div_fall[0], and Div_fall[1].
- NUM=1, DEN=4: drop Run while Cen_lvl=0 -> DRAIN, then HALT on the next rise with Stopped=1 and Cen_lvl=1. Hold 10 Clk: no strobes, acc unchanged. Raise Run -> Stopped=0 next edge; the next fall lands exactly 2 Clk after resume.
- Drop Run while Cen_lvl=1 with no toggle pending -> HALT immediately (Stopped=1 on the next edge), zero extra strobes.
- Assert Reset_n=0 for 1 Clk mid-DRAIN with Div_lvl=3'b101 -> next edge shows acc=0, Cen_lvl=1, Div_lvl=0, Stopped=0, all strobes 0.

Source files
------------

// File: rtl/ttl_timing_pkg.sv
// Shared timing definitions for the emulated-clock enable generator:
// FSM encodings and elaboration-time parameter legality helpers.
package ttl_timing_pkg;

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN   = RUN,
    ST_DRAIN = DRAIN,
    ST_HALT  = HALT
  } state_t;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // The accumulator must hold DEN + 2*NUM without wrapping.
  function automatic bit params_ok(input int num, input int den,
                                   input int acc_w, input int div_stages);
    return (num >= 1) && (2 * num <= den) &&
           (clog2(den + 2 * num + 1) <= acc_w) &&
           (div_stages >= 1) && (div_stages <= 8);
  endfunction

endpackage

// File: rtl/ttl_cen_div_stage.sv
// One J=K=1 divide-by-2 stage, clocked by the falling edge of the stage
// before it (expressed as an enable strobe in the Clk domain).
module ttl_cen_div_stage (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Hold,
  input  logic Fall_in,
  output logic Lvl,
  output logic Fall_out,
  output logic Fall_q
);

  assign Fall_out = Fall_in & Lvl;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      Lvl    <= 1'b0;
      Fall_q <= 1'b0;
    end else if (Hold) begin
      Fall_q <= 1'b0;
    end else begin
      if (Fall_in) Lvl <= ~Lvl;
      Fall_q <= Fall_in & Lvl;
    end
  end

endmodule

// File: rtl/ttl_cen_gen_sync.sv
// Emulated master clock: fractional-N accumulator driving a level plus
// edge strobes, a ripple divider chain, and a clean pause handshake.
module ttl_cen_gen_sync
  import ttl_timing_pkg::*;
#(
  parameter int NUM        = 1,
  parameter int DEN        = 4,
  parameter int ACC_W      = 16,
  parameter int DIV_STAGES = 3
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Run,
  output logic                  Cen_lvl,
  output logic                  Cen_rise,
  output logic                  Cen_fall,
  output logic [DIV_STAGES-1:0] Div_lvl,
  output logic [DIV_STAGES-1:0] Div_fall,
  output logic                  Stopped,
  output logic [1:0]            Dbg_state
);

  if (!params_ok(NUM, DEN, ACC_W, DIV_STAGES)) begin : g_param_err
    $error("ttl_cen_gen_sync: illegal NUM/DEN/ACC_W/DIV_STAGES combination");
  end

  localparam logic [ACC_W-1:0] STEP  = ACC_W'(2 * NUM);
  localparam logic [ACC_W-1:0] DEN_V = ACC_W'(DEN);

  state_t                 state;
  logic [ACC_W-1:0]       acc;
  logic [ACC_W-1:0]       sum;
  logic                   advancing;
  logic                   hold;
  logic                   toggle;
  logic [DIV_STAGES:0]    fall_chain;
  logic                   unused_chain_end;

  assign advancing = (state != ST_HALT);
  assign hold      = ~advancing;
  assign sum       = acc + STEP;
  assign toggle    = advancing && (sum >= DEN_V);
  assign Dbg_state = state;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      acc      <= '0;
      Cen_lvl  <= 1'b1;
      Cen_rise <= 1'b0;
      Cen_fall <= 1'b0;
      Stopped  <= 1'b0;
      state    <= ST_RUN;
    end else begin
      Cen_rise <= toggle & ~Cen_lvl;
      Cen_fall <= toggle & Cen_lvl;
      if (advancing) begin
        acc <= toggle ? (sum - DEN_V) : sum;
        if (toggle) Cen_lvl <= ~Cen_lvl;
      end
      // Halting is only allowed where Cen_lvl ends up high: either it is
      // already high and stays so, or this cycle's toggle is a rise.
      case (state)
        ST_RUN: begin
          if (!Run) begin
            if (Cen_lvl ^ toggle) begin
              state   <= ST_HALT;
              Stopped <= 1'b1;
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (Run) begin
            state <= ST_RUN;
          end else if (toggle && !Cen_lvl) begin
            state   <= ST_HALT;
            Stopped <= 1'b1;
          end
        end
        ST_HALT: begin
          if (Run) begin
            state   <= ST_RUN;
            Stopped <= 1'b0;
          end
        end
        default: begin
          state   <= ST_RUN;
          Stopped <= 1'b0;
        end
      endcase
    end
  end

  assign fall_chain[0] = toggle & Cen_lvl;

  for (genvar k = 0; k < DIV_STAGES; k++) begin : g_div
    ttl_cen_div_stage u_stage (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .Hold     (hold),
      .Fall_in  (fall_chain[k]),
      .Lvl      (Div_lvl[k]),
      .Fall_out (fall_chain[k+1]),
      .Fall_q   (Div_fall[k])
    );
  end

  assign unused_chain_end = fall_chain[DIV_STAGES];

endmodule

// File: tb/tb_ttl_cen_gen_sync.sv
// Directed bench for ttl_cen_gen_sync: three instances cover the 1/4, 3/8
// and 1/2 ratios; the 1/4 instance also exercises pause and reset.
module tb_ttl_cen_gen_sync;

  logic clk;
  logic rst_n;
  logic run_a, run_bc;

  logic a_lvl, a_rise, a_fall, a_stopped;
  logic [2:0] a_div, a_divf;
  logic [1:0] a_state;
  logic b_lvl, b_rise, b_fall, b_stopped;
  logic [2:0] b_div, b_divf;
  logic [1:0] b_state;
  logic c_lvl, c_rise, c_fall, c_stopped;
  logic [2:0] c_div, c_divf;
  logic [1:0] c_state;

  int checks = 0;
  int failures = 0;

  ttl_cen_gen_sync #(.NUM(1), .DEN(4), .ACC_W(16), .DIV_STAGES(3)) u_a (
    .Clk(clk), .Reset_n(rst_n), .Run(run_a), .Cen_lvl(a_lvl), .Cen_rise(a_rise),
    .Cen_fall(a_fall), .Div_lvl(a_div), .Div_fall(a_divf), .Stopped(a_stopped),
    .Dbg_state(a_state));

  ttl_cen_gen_sync #(.NUM(3), .DEN(8), .ACC_W(16), .DIV_STAGES(3)) u_b (
    .Clk(clk), .Reset_n(rst_n), .Run(run_bc), .Cen_lvl(b_lvl), .Cen_rise(b_rise),
    .Cen_fall(b_fall), .Div_lvl(b_div), .Div_fall(b_divf), .Stopped(b_stopped),
    .Dbg_state(b_state));

  ttl_cen_gen_sync #(.NUM(1), .DEN(2), .ACC_W(16), .DIV_STAGES(3)) u_c (
    .Clk(clk), .Reset_n(rst_n), .Run(run_bc), .Cen_lvl(c_lvl), .Cen_rise(c_rise),
    .Cen_fall(c_fall), .Div_lvl(c_div), .Div_fall(c_divf), .Stopped(c_stopped),
    .Dbg_state(c_state));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run_a = 1'b1; run_bc = 1'b1;
    step();
    step();
    checks++; if (a_lvl !== 1'b1) begin failures++; $display("FAIL reset_a_lvl got=%b exp=1", a_lvl); end
    checks++; if ({a_rise, a_fall} !== 2'b00) begin failures++; $display("FAIL reset_a_strobes got=%b exp=00", {a_rise, a_fall}); end
    checks++; if (a_div !== 3'b000 || a_divf !== 3'b000) begin failures++; $display("FAIL reset_a_div got=%b/%b exp=000/000", a_div, a_divf); end
    checks++; if (a_stopped !== 1'b0 || a_state !== 2'd0) begin failures++; $display("FAIL reset_a_fsm got=%b/%0d exp=0/0", a_stopped, a_state); end
    checks++; if (c_lvl !== 1'b1 || c_div !== 3'b000 || c_stopped !== 1'b0) begin failures++; $display("FAIL reset_c got=%b/%b/%b exp=1/000/0", c_lvl, c_div, c_stopped); end
  endtask

  task automatic test_basic_rate();
    logic [7:0] exp_lvl, exp_fall, exp_rise;
    exp_lvl  = 8'b1001_1001;
    exp_fall = 8'b0010_0010;
    exp_rise = 8'b1000_1000;
    do_reset();
    for (int e = 0; e < 8; e++) begin
      step();
      checks++; if (a_lvl !== exp_lvl[e]) begin failures++; $display("FAIL basic_lvl edge=%0d got=%b exp=%b", e + 1, a_lvl, exp_lvl[e]); end
      checks++; if (a_fall !== exp_fall[e] || a_rise !== exp_rise[e]) begin failures++; $display("FAIL basic_strobe edge=%0d got=%b%b exp=%b%b", e + 1, a_rise, a_fall, exp_rise[e], exp_fall[e]); end
    end
  endtask

  task automatic test_fractional();
    logic lvl;
    logic tog;
    int rises, falls;
    lvl = 1'b1; rises = 0; falls = 0;
    do_reset();
    for (int e = 1; e <= 16; e++) begin
      step();
      tog = ((e % 4) != 1);
      checks++; if (b_rise !== (tog & ~lvl) || b_fall !== (tog & lvl)) begin failures++; $display("FAIL frac_strobe edge=%0d got=%b%b exp=%b%b", e, b_rise, b_fall, tog & ~lvl, tog & lvl); end
      rises += int'(b_rise);
      falls += int'(b_fall);
      if (tog) lvl = ~lvl;
    end
    checks++; if (rises != 6 || falls != 6) begin failures++; $display("FAIL frac_counts got=%0d/%0d exp=6/6", rises, falls); end
  endtask

  task automatic test_divider();
    logic [2:0] cnt, prev;
    logic odd;
    cnt = 3'd0;
    do_reset();
    for (int e = 1; e <= 16; e++) begin
      step();
      odd = e[0];
      prev = cnt;
      if (odd) cnt = cnt + 3'd1;
      checks++; if (c_fall !== odd) begin failures++; $display("FAIL div_cen_fall edge=%0d got=%b exp=%b", e, c_fall, odd); end
      checks++; if (c_div !== cnt) begin failures++; $display("FAIL div_lvl edge=%0d got=%b exp=%b", e, c_div, cnt); end
      checks++; if (c_divf !== (odd ? (prev & ~cnt) : 3'b000)) begin failures++; $display("FAIL div_fall edge=%0d got=%b exp=%b", e, c_divf, odd ? (prev & ~cnt) : 3'b000); end
    end
  endtask

  task automatic test_halt_drain();
    do_reset();
    run_a = 1'b1;
    step();
    step();
    checks++; if (a_fall !== 1'b1 || a_lvl !== 1'b0) begin failures++; $display("FAIL drain_pre got=%b/%b exp=1/0", a_fall, a_lvl); end
    run_a = 1'b0;
    step();
    checks++; if (a_state !== 2'd1 || a_stopped !== 1'b0 || a_lvl !== 1'b0) begin failures++; $display("FAIL drain_enter got=%0d/%b/%b exp=1/0/0", a_state, a_stopped, a_lvl); end
    step();
    checks++; if (a_rise !== 1'b1 || a_lvl !== 1'b1 || a_stopped !== 1'b1 || a_state !== 2'd2) begin failures++; $display("FAIL drain_halt got=%b/%b/%b/%0d exp=1/1/1/2", a_rise, a_lvl, a_stopped, a_state); end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (a_stopped !== 1'b1 || a_lvl !== 1'b1 || {a_rise, a_fall} !== 2'b00 || a_div !== 3'b001 || a_divf !== 3'b000) begin failures++; $display("FAIL halt_hold cyc=%0d got=%b/%b/%b%b/%b/%b exp=1/1/00/001/000", i, a_stopped, a_lvl, a_rise, a_fall, a_div, a_divf); end
    end
    run_a = 1'b1;
    step();
    checks++; if (a_stopped !== 1'b0 || a_state !== 2'd0 || {a_rise, a_fall} !== 2'b00 || a_lvl !== 1'b1) begin failures++; $display("FAIL resume got=%b/%0d/%b%b/%b exp=0/0/00/1", a_stopped, a_state, a_rise, a_fall, a_lvl); end
    step();
    checks++; if (a_fall !== 1'b0 || a_lvl !== 1'b1) begin failures++; $display("FAIL resume_plus1 got=%b/%b exp=0/1", a_fall, a_lvl); end
    step();
    checks++; if (a_fall !== 1'b1 || a_lvl !== 1'b0 || a_div !== 3'b010 || a_divf !== 3'b001) begin failures++; $display("FAIL resume_fall got=%b/%b/%b/%b exp=1/0/010/001", a_fall, a_lvl, a_div, a_divf); end
  endtask

  task automatic test_halt_immediate();
    do_reset();
    run_a = 1'b1;
    repeat (4) step();
    checks++; if (a_lvl !== 1'b1 || a_rise !== 1'b1) begin failures++; $display("FAIL imm_pre got=%b/%b exp=1/1", a_lvl, a_rise); end
    run_a = 1'b0;
    step();
    checks++; if (a_stopped !== 1'b1 || a_state !== 2'd2 || a_lvl !== 1'b1 || {a_rise, a_fall} !== 2'b00) begin failures++; $display("FAIL imm_halt got=%b/%0d/%b/%b%b exp=1/2/1/00", a_stopped, a_state, a_lvl, a_rise, a_fall); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({a_rise, a_fall} !== 2'b00 || a_stopped !== 1'b1) begin failures++; $display("FAIL imm_hold cyc=%0d got=%b%b/%b exp=00/1", i, a_rise, a_fall, a_stopped); end
    end
    run_a = 1'b1;
    step();
    checks++; if (a_stopped !== 1'b0 || a_fall !== 1'b0) begin failures++; $display("FAIL imm_resume got=%b/%b exp=0/0", a_stopped, a_fall); end
    step();
    checks++; if (a_fall !== 1'b1 || a_lvl !== 1'b0) begin failures++; $display("FAIL imm_phase got=%b/%b exp=1/0", a_fall, a_lvl); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    run_a = 1'b1;
    repeat (18) step();
    checks++; if (a_div !== 3'b101 || a_lvl !== 1'b0) begin failures++; $display("FAIL mid_pre got=%b/%b exp=101/0", a_div, a_lvl); end
    run_a = 1'b0;
    step();
    checks++; if (a_state !== 2'd1 || a_div !== 3'b101) begin failures++; $display("FAIL mid_drain got=%0d/%b exp=1/101", a_state, a_div); end
    rst_n = 1'b0;
    step();
    checks++; if (a_lvl !== 1'b1 || a_div !== 3'b000 || a_stopped !== 1'b0 || a_state !== 2'd0) begin failures++; $display("FAIL mid_reset got=%b/%b/%b/%0d exp=1/000/0/0", a_lvl, a_div, a_stopped, a_state); end
    checks++; if ({a_rise, a_fall, a_divf} !== 5'b00000) begin failures++; $display("FAIL mid_reset_strobes got=%b exp=00000", {a_rise, a_fall, a_divf}); end
    rst_n = 1'b1;
    run_a = 1'b1;
    step();
    checks++; if (a_fall !== 1'b0 || a_lvl !== 1'b1) begin failures++; $display("FAIL mid_acc_e1 got=%b/%b exp=0/1", a_fall, a_lvl); end
    step();
    checks++; if (a_fall !== 1'b1 || a_lvl !== 1'b0) begin failures++; $display("FAIL mid_acc_e2 got=%b/%b exp=1/0", a_fall, a_lvl); end
  endtask

  initial begin
    rst_n = 1'b0;
    run_a = 1'b1;
    run_bc = 1'b1;
    test_reset();
    test_basic_rate();
    test_fractional();
    test_divider();
    test_halt_drain();
    test_halt_immediate();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
